hs_ram_bridge: RTL

HS_RAM_BRIDGE -- requirements
Module: hs_ram_bridge

---
 rtl/hs_ram_bridge.sv | 105 ++++++++++
 1 files changed

// File: rtl/hs_ram_bridge.sv
// Arbitrates a single-port work RAM between the game CPU and the hiscore engine.
// Optional address range checking is enabled with `define HS_BOUNDS_CHECK_EN.
module hs_ram_bridge #(
  parameter int AW        = 11,
  parameter int RAM_WORDS = 2048
) (
  input  logic          MCLK,
  input  logic          RESET,
  input  logic          PAUSE,
  input  logic          hs_access,
  input  logic [AW-1:0] hs_address,
  input  logic [7:0]    hs_data_in,
  input  logic          hs_write,
  output logic [7:0]    hs_data_out,
  output logic          hs_ready,
  output logic          hs_err,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          cpu_we,
  output logic          cpu_blocked,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  input  logic [7:0]    ram_rdata
);

  typedef enum logic [1:0] {IDLE, ARM, GRANT, DRAIN} state_e;

  state_e     state_q, state_d;
  logic       hs_ready_q, hs_ready_d;
  logic       cpu_blocked_q, cpu_blocked_d;
  logic [7:0] hs_data_out_q, hs_data_out_d;
  logic       hs_err_q, hs_err_d;
  logic       oob_q, oob_d;
  logic       oob;

`ifdef HS_BOUNDS_CHECK_EN
  localparam logic [AW:0] RAM_LIM = (AW+1)'(RAM_WORDS);
  assign oob = ({1'b0, hs_address} >= RAM_LIM);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs_access && PAUSE) state_d = ARM;
      ARM:     state_d = (hs_access && PAUSE) ? GRANT : IDLE;
      GRANT:   if (!hs_access) state_d = DRAIN;
      default: state_d = IDLE;
    endcase

    hs_ready_d    = (state_d == GRANT);
    cpu_blocked_d = (state_d != IDLE);

    // oob_q tags the address whose data arrives on ram_rdata this cycle
    oob_d = (state_q == GRANT) && oob;

    hs_data_out_d = hs_data_out_q;
    if (state_q == GRANT && !hs_write)
      hs_data_out_d = oob_q ? 8'h00 : ram_rdata;

    hs_err_d = hs_err_q | ((state_q == GRANT) && oob);
  end

  // ARM keeps the CPU on the RAM so a write already in flight completes
  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_din;
    ram_we    = 1'b0;
    case (state_q)
      IDLE, ARM: ram_we = cpu_we;
      GRANT: begin
        ram_addr  = hs_address;
        ram_wdata = hs_data_in;
        ram_we    = hs_write && !oob;
      end
      default: ram_we = 1'b0;
    endcase
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      hs_ready_q    <= 1'b0;
      cpu_blocked_q <= 1'b0;
      hs_data_out_q <= 8'h00;
      hs_err_q      <= 1'b0;
      oob_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_ready_q    <= hs_ready_d;
      cpu_blocked_q <= cpu_blocked_d;
      hs_data_out_q <= hs_data_out_d;
      hs_err_q      <= hs_err_d;
      oob_q         <= oob_d;
    end
  end

  assign hs_ready    = hs_ready_q;
  assign cpu_blocked = cpu_blocked_q;
  assign hs_data_out = hs_data_out_q;
  assign hs_err      = hs_err_q;

endmodule
